// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/sub built from 4-bit CLA groups, one segment per stage.
// Define ADDSUB_SAT_EN to clamp signed overflow and expose the sat port.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef ADDSUB_SAT_EN
    output logic             sat,
`endif
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;
    localparam int NG  = SEG / 4;

    if (STAGES < 1 || (WIDTH % (4 * STAGES)) != 0) begin : bad_cfg
        $error("pipelined_cla_addsub: WIDTH must be a multiple of 4*STAGES");
    end

    // Returns {carry_out, sum}; group carries are pure lookahead terms.
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG:0]   c;
        logic [NG-1:0]  gp;
        logic [NG-1:0]  gg;
        logic [NG:0]    gc;
        logic           t;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (&p[4*j+2 +: 2] & g[4*j+1])
                  | (&p[4*j+1 +: 3] & g[4*j]);
        end
        for (int j = 0; j <= NG; j++) begin
            t = ci;
            for (int i = 0; i < j; i++) t = t & gp[i];
            gc[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int l = i + 1; l < j; l++) t = t & gp[l];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (&p[4*j +: 2] & gc[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (&p[4*j+1 +: 2] & g[4*j])
                     | (&p[4*j +: 3] & gc[j]);
        end
        c[SEG] = gc[NG];
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : st
        localparam int LO = k * SEG;
        localparam int HI = WIDTH - LO;

        logic              v_i;
        logic              c_i;
        logic [HI-1:0]     a_i;
        logic [HI-1:0]     b_i;
        logic [SEG:0]      sc;
        logic [LO+SEG-1:0] r_c;
        logic [LO+SEG-1:0] r_n;
        logic              v_q;
        logic              c_q;
        logic [LO+SEG-1:0] r_q;

        if (k == 0) begin : src
            assign v_i = in_valid;
            assign c_i = sub;
            assign a_i = a;
            assign b_i = sub ? ~b : b;
            assign r_c = sc[SEG-1:0];
        end else begin : src
            assign v_i = st[k-1].v_q;
            assign c_i = st[k-1].c_q;
            assign a_i = st[k-1].rem.a_q;
            assign b_i = st[k-1].rem.b_q;
            assign r_c = {sc[SEG-1:0], st[k-1].r_q};
        end

        assign sc = seg_add(a_i[SEG-1:0], b_i[SEG-1:0], c_i);

        if (k < STAGES - 1) begin : rem
            logic [HI-SEG-1:0] a_q;
            logic [HI-SEG-1:0] b_q;

            assign r_n = r_c;

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a_i[HI-1:SEG];
                    b_q <= b_i[HI-1:SEG];
                end
            end
        end else begin : fin
            logic o_n;
            logic o_q;

            // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
            assign o_n = sc[SEG] ^ sc[SEG-1] ^ a_i[SEG-1] ^ b_i[SEG-1];

`ifdef ADDSUB_SAT_EN
            logic s_q;

            assign r_n = o_n ? {sc[SEG], {(WIDTH-1){~sc[SEG]}}} : r_c;

            always_ff @(posedge clk) begin
                if (!rst_n) s_q <= 1'b0;
                else if (advance) s_q <= o_n;
            end
`else
            assign r_n = r_c;
`endif

            always_ff @(posedge clk) begin
                if (!rst_n) o_q <= 1'b0;
                else if (advance) o_q <= o_n;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (advance) begin
                v_q <= v_i;
                c_q <= sc[SEG];
                r_q <= r_n;
            end
        end
    end

    assign out_valid = st[STAGES-1].v_q;
    assign sum       = st[STAGES-1].r_q;
    assign c_out     = st[STAGES-1].c_q;
    assign ovf       = st[STAGES-1].fin.o_q;
`ifdef ADDSUB_SAT_EN
    assign sat       = st[STAGES-1].fin.s_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (WIDTH=32, STAGES=4).
// Honours ADDSUB_SAT_EN when the design is built with it.
module tb_pipelined_cla_addsub;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
`ifdef ADDSUB_SAT_EN
    logic        sat;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    logic [3:0] mv;
    exp_t q[$];

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .c_out(c_out),
`ifdef ADDSUB_SAT_EN
        .sat(sat),
`endif
        .ovf(ovf)
    );

    function automatic exp_t mk(input logic [31:0] s, input logic c,
                                input logic o);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic s);
        logic [31:0] be;
        logic [32:0] t;
        exp_t e;
        be = s ? ~y : y;
        t = {1'b0, x} + {1'b0, be} + 33'(s);
        e.s = t[31:0];
        e.c = t[32];
        e.o = (x[31] == be[31]) && (t[31] != x[31]);
`ifdef ADDSUB_SAT_EN
        if (e.o) e.s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out();
        exp_t e;
        chk("out_valid", 32'(out_valid), 32'(mv[3]));
        if (mv[3]) begin
            e = q[0];
            chk("sum", sum, e.s);
            chk("c_out", 32'(c_out), 32'(e.c));
            chk("ovf", 32'(ovf), 32'(e.o));
`ifdef ADDSUB_SAT_EN
            chk("sat", 32'(sat), 32'(e.o));
`endif
        end
    endtask

    // One clock: drive, check in_ready, advance model, check outputs.
    task automatic cyc(input logic iv, input logic [31:0] ia,
                       input logic [31:0] ib, input logic is,
                       input logic ordy, input logic use_k,
                       input exp_t k, output logic acc);
        logic adv;
        rst_n = 1'b1;
        in_valid = iv;
        a = ia;
        b = ib;
        sub = is;
        out_ready = ordy;
        #1;
        adv = !mv[3] || ordy;
        chk("in_ready", 32'(in_ready), 32'(adv));
        @(posedge clk);
        acc = adv && iv;
        if (mv[3] && ordy && q.size() > 0) void'(q.pop_front());
        if (adv) begin
            mv = {mv[2:0], iv};
            if (iv) begin
                q.push_back(use_k ? k : model(ia, ib, is));
                n_acc++;
            end
        end
        @(negedge clk);
        chk_out();
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
        out_ready = 1'b0;
        @(posedge clk);
        mv = '0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDSUB_SAT_EN
        chk("rst_sat", 32'(sat), 32'd0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [7:0]  pat;
        logic [31:0] sa [8];
        logic [31:0] sb [8];
        logic        ss [8];
        logic [31:0] corner [4];
        int          i;
        int          c;
        int          target;
        exp_t        k_ovf_sub;
        exp_t        k_ovf_add;

        mv = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

`ifdef ADDSUB_SAT_EN
        k_ovf_sub = mk(32'h8000_0000, 1'b1, 1'b1);
        k_ovf_add = mk(32'h7FFF_FFFF, 1'b0, 1'b1);
`else
        k_ovf_sub = mk(32'h7FFF_FFFF, 1'b1, 1'b1);
        k_ovf_add = mk(32'h8000_0000, 1'b0, 1'b1);
`endif

        // Single op, then idle: out_valid must rise on the 4th edge.
        cyc(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1,
            mk(32'h0, 1'b1, 1'b0), acc);
        idle(5);

        cyc(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1,
            mk(32'hFFFF_FFFE, 1'b0, 1'b0), acc);
        cyc(1'b1, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1, k_ovf_sub, acc);
        cyc(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, k_ovf_add, acc);
        idle(6);

        // Back-to-back stream under a fixed out_ready pattern.
        pat = 8'b1101_1001;
        sa = '{32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF,
               32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_FFFF};
        sb = '{32'h2, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1111_1111,
               32'h1, 32'hFFFF_FFFF, 32'h8765_4321, 32'h0000_0001};
        ss = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        i = 0;
        c = 0;
        while (i < 8 && c < 64) begin
            cyc(1'b1, sa[i], sb[i], ss[i], pat[c % 8], 1'b0, '0, acc);
            if (acc) i++;
            c++;
        end
        chk("stream_accepts", 32'(i), 32'd8);
        idle(6);

        // Reset with three ops in flight: none may emerge.
        for (int j = 0; j < 3; j++)
            cyc(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0, '0, acc);
        do_reset();
        idle(6);

        corner = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        target = n_acc + 10000;
        c = 0;
        while (n_acc < target && c < 40000) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)]
                                             : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)]
                                             : $urandom;
            cyc($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, 1'b0, '0, acc);
            c++;
        end
        chk("random_accepts", 32'(n_acc >= target), 32'd1);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
